// File: rtl/im_port_if.sv
// Bundle of the fetch port, debug/loader port and instruction-memory port
// seen by the instruction-memory arbiter.
interface im_port_if #(
   parameter int AW = 11
);
   logic          if_req;
   logic [31:0]   if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [31:0]   if_rdata;
   logic          if_err;

   logic          dbg_req;
   logic          dbg_we;
   logic [31:0]   dbg_addr;
   logic [31:0]   dbg_wdata;
   logic          dbg_halt;
   logic          dbg_gnt;
   logic          dbg_rvalid;
   logic          dbg_err;
   logic [31:0]   dbg_rdata;

   logic          mem_ena;
   logic          mem_wea;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_dina;
   logic [31:0]   mem_douta;

   logic [15:0]   stall_cnt;

   // Arbiter side
   modport slave (
      input  if_req, if_addr,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
      input  mem_douta,
      output if_gnt, if_rvalid, if_rdata, if_err,
      output dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata,
      output mem_ena, mem_wea, mem_addr, mem_dina,
      output stall_cnt
   );

   // Requester / memory side
   modport master (
      output if_req, if_addr,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
      output mem_douta,
      input  if_gnt, if_rvalid, if_rdata, if_err,
      input  dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata,
      input  mem_ena, mem_wea, mem_addr, mem_dina,
      input  stall_cnt
   );
endinterface

// File: rtl/im_port_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between instruction
// fetch and a debug/loader port, with a fixed one-cycle response path.
module im_port_arbiter #(
   parameter int AW = 11
) (
   input logic       clk,
   input logic       rst,
   im_port_if.slave  bus
);

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DBG   = 1'b1
   } owner_t;

   owner_t        last_gnt_reg;
   owner_t        resp_owner_reg;
   logic          resp_valid_reg;
   logic          resp_write_reg;
   logic          resp_err_reg;
   logic [15:0]   stall_cnt_reg;

   logic          fetch_elig;
   logic          dbg_elig;
   logic          gnt_fetch;
   logic          gnt_dbg;
   logic          any_gnt;
   logic [31:0]   sel_addr;
   logic          addr_legal;
   logic          if_resp;
   logic          dbg_resp;
   logic [31:0]   resp_data;

   // Grants are gated by rst so every request-side output is quiet during reset.
   always_comb begin
      fetch_elig = bus.if_req & ~bus.dbg_halt & ~rst;
      dbg_elig   = bus.dbg_req & ~rst;
      gnt_dbg    = dbg_elig & (~fetch_elig | (last_gnt_reg == OWN_FETCH));
      gnt_fetch  = fetch_elig & ~gnt_dbg;
      any_gnt    = gnt_fetch | gnt_dbg;
      sel_addr   = gnt_dbg ? bus.dbg_addr : bus.if_addr;
      addr_legal = (sel_addr[1:0] == 2'b00) && (sel_addr[31:AW+2] == '0);
   end

   assign bus.if_gnt   = gnt_fetch;
   assign bus.dbg_gnt  = gnt_dbg;
   assign bus.mem_ena  = any_gnt & addr_legal;
   assign bus.mem_wea  = gnt_dbg & bus.dbg_we & addr_legal;
   assign bus.mem_addr = sel_addr[AW+1:2];
   assign bus.mem_dina = bus.dbg_wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt_reg   <= OWN_DBG;
         resp_owner_reg <= OWN_FETCH;
         resp_valid_reg <= 1'b0;
         resp_write_reg <= 1'b0;
         resp_err_reg   <= 1'b0;
      end else begin
         resp_valid_reg <= any_gnt;
         if (any_gnt) begin
            resp_owner_reg <= gnt_dbg ? OWN_DBG : OWN_FETCH;
            resp_write_reg <= gnt_dbg & bus.dbg_we;
            resp_err_reg   <= ~addr_legal;
            last_gnt_reg   <= gnt_dbg ? OWN_DBG : OWN_FETCH;
         end
      end
   end

   // Starvation counter saturates instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_reg <= '0;
      end else if (bus.if_req && !gnt_fetch && (stall_cnt_reg != 16'hFFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
   end

   assign bus.stall_cnt = stall_cnt_reg;

   always_comb begin
      if_resp   = resp_valid_reg & (resp_owner_reg == OWN_FETCH);
      dbg_resp  = resp_valid_reg & (resp_owner_reg == OWN_DBG);
      resp_data = (resp_write_reg | resp_err_reg) ? 32'd0 : bus.mem_douta;
   end

   assign bus.if_rvalid  = if_resp;
   assign bus.if_err     = if_resp & resp_err_reg;
   assign bus.if_rdata   = if_resp ? resp_data : 32'd0;
   assign bus.dbg_rvalid = dbg_resp;
   assign bus.dbg_err    = dbg_resp & resp_err_reg;
   assign bus.dbg_rdata  = dbg_resp ? resp_data : 32'd0;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Bench for im_port_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level reference model.
module tb_im_port_arbiter;

   localparam int AW    = 11;
   localparam int WORDS = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b0;

   im_port_if #(.AW(AW)) bus ();

   im_port_arbiter #(.AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // Memory device attached to the DUT's memory port (read-first, 1-cycle read).
   logic [31:0] tb_mem [WORDS];

   always @(posedge clk) begin
      if (bus.mem_ena) begin
         if (bus.mem_wea) tb_mem[bus.mem_addr] <= bus.mem_dina;
         bus.mem_douta <= tb_mem[bus.mem_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: memory contents, last winner, one pending response, stall count.
   logic [31:0] model_mem [WORDS];
   bit          m_last_dbg;
   bit          m_pend_v;
   bit          m_pend_dbg;
   bit          m_pend_wr;
   bit          m_pend_err;
   logic [31:0] m_pend_data;
   int          m_stall;

   always @(negedge clk) begin
      bit          f_el, d_el, e_gf, e_gd, legal, e_ena, e_wea;
      logic [31:0] addr, e_data;
      int          word;
      if (rst) begin
         chk("rst if_gnt", 32'(bus.if_gnt), 0);
         chk("rst dbg_gnt", 32'(bus.dbg_gnt), 0);
         chk("rst mem_ena", 32'(bus.mem_ena), 0);
         chk("rst mem_wea", 32'(bus.mem_wea), 0);
         chk("rst if_rvalid", 32'(bus.if_rvalid), 0);
         chk("rst dbg_rvalid", 32'(bus.dbg_rvalid), 0);
         chk("rst if_err", 32'(bus.if_err), 0);
         chk("rst dbg_err", 32'(bus.dbg_err), 0);
         chk("rst if_rdata", bus.if_rdata, 0);
         chk("rst dbg_rdata", bus.dbg_rdata, 0);
         chk("rst stall_cnt", 32'(bus.stall_cnt), 0);
         m_pend_v   = 0;
         m_last_dbg = 1;
         m_stall    = 0;
      end else begin
         f_el = bus.if_req && !bus.dbg_halt;
         d_el = bus.dbg_req;
         e_gf = 0;
         e_gd = 0;
         if (f_el && d_el) begin
            if (m_last_dbg) e_gf = 1; else e_gd = 1;
         end else if (f_el) e_gf = 1;
         else if (d_el) e_gd = 1;
         addr  = e_gd ? bus.dbg_addr : bus.if_addr;
         legal = (addr % 4 == 0) && (addr < 32'(WORDS * 4));
         word  = int'(addr / 4);
         e_ena = (e_gf || e_gd) && legal;
         e_wea = e_ena && e_gd && bus.dbg_we;

         chk("if_gnt", 32'(bus.if_gnt), 32'(e_gf));
         chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(e_gd));
         chk("mem_ena", 32'(bus.mem_ena), 32'(e_ena));
         chk("mem_wea", 32'(bus.mem_wea), 32'(e_wea));
         if (e_ena) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(word));
            chk("mem_dina", bus.mem_dina, bus.dbg_wdata);
         end

         e_data = (m_pend_v && !m_pend_err && !m_pend_wr) ? m_pend_data : 32'd0;
         chk("if_rvalid", 32'(bus.if_rvalid), 32'(m_pend_v && !m_pend_dbg));
         chk("if_err", 32'(bus.if_err), 32'(m_pend_v && !m_pend_dbg && m_pend_err));
         chk("if_rdata", bus.if_rdata, m_pend_dbg ? 32'd0 : e_data);
         chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(m_pend_v && m_pend_dbg));
         chk("dbg_err", 32'(bus.dbg_err), 32'(m_pend_v && m_pend_dbg && m_pend_err));
         chk("dbg_rdata", bus.dbg_rdata, m_pend_dbg ? e_data : 32'd0);
         chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));

         m_pend_v = e_gf || e_gd;
         if (m_pend_v) begin
            m_pend_dbg  = e_gd;
            m_pend_wr   = e_gd && bus.dbg_we;
            m_pend_err  = !legal;
            m_pend_data = legal ? model_mem[word] : 32'd0;
            if (e_wea) model_mem[word] = bus.dbg_wdata;
            m_last_dbg = e_gd;
            $display("t=%0t grant %s addr=%h we=%0d legal=%0d", $time,
                     e_gd ? "dbg  " : "fetch", addr, m_pend_wr, legal);
         end
         if (bus.if_req && !e_gf && m_stall < 65535) m_stall++;
      end
   end

   function automatic logic [31:0] rand_addr();
      int r = $urandom_range(0, 19);
      if (r == 0) return $urandom() | 32'h1;
      if (r == 1) return 32'h0000_2000 | (32'($urandom_range(0, 255)) << 2);
      return 32'($urandom_range(0, 31)) << 2;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   bit g_f, g_d;

   initial begin
      for (int i = 0; i < WORDS; i++) begin
         tb_mem[i]    = {16'hC0DE, 16'(i)};
         model_mem[i] = {16'hC0DE, 16'(i)};
      end
      bus.if_req = 0; bus.if_addr = 0;
      bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0; bus.dbg_halt = 0;
      bus.mem_douta = 0;
      #1 rst = 1;
      repeat (3) @(posedge clk);

      // Single fetch right after reset release
      #1 rst = 0; bus.if_req = 1; bus.if_addr = 32'h10;
      #3 chk("d1 if_gnt", 32'(bus.if_gnt), 1);
      chk("d1 mem_addr", 32'(bus.mem_addr), 4);
      chk("d1 mem_wea", 32'(bus.mem_wea), 0);
      next_cycle(); bus.if_req = 0;
      #3 chk("d1 if_rvalid", 32'(bus.if_rvalid), 1);
      chk("d1 if_rdata", bus.if_rdata, 32'hC0DE0004);

      // Continuous contention after a fresh reset: F, D, F, D
      next_cycle(); rst = 1;
      next_cycle(); next_cycle();
      rst = 0;
      bus.if_req = 1; bus.if_addr = 32'h40;
      bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 32'h44;
      for (int i = 0; i < 5; i++) begin
         #3;
         if (i < 4) begin
            chk("rr if_gnt", 32'(bus.if_gnt), 32'(i % 2 == 0));
            chk("rr dbg_gnt", 32'(bus.dbg_gnt), 32'(i % 2 == 1));
         end
         if (i > 0) begin
            chk("rr if_rvalid", 32'(bus.if_rvalid), 32'(i % 2 == 1));
            chk("rr dbg_rvalid", 32'(bus.dbg_rvalid), 32'(i % 2 == 0));
            chk("rr rdata", bus.if_rdata | bus.dbg_rdata,
                (i % 2 == 1) ? 32'hC0DE0010 : 32'hC0DE0011);
         end
         next_cycle();
         if (i == 3) begin bus.if_req = 0; bus.dbg_req = 0; end
      end

      // Debug write, then fetch of the same word
      bus.if_req = 0;
      bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h20; bus.dbg_wdata = 32'hDEADBEEF;
      #3 chk("wr dbg_gnt", 32'(bus.dbg_gnt), 1);
      chk("wr mem_wea", 32'(bus.mem_wea), 1);
      chk("wr mem_addr", 32'(bus.mem_addr), 8);
      next_cycle(); bus.dbg_req = 0; bus.dbg_we = 0; bus.if_req = 1; bus.if_addr = 32'h20;
      #3 chk("wr dbg_rvalid", 32'(bus.dbg_rvalid), 1);
      chk("wr dbg_rdata", bus.dbg_rdata, 0);
      chk("wr if_gnt", 32'(bus.if_gnt), 1);
      next_cycle(); bus.if_req = 0;
      #3 chk("wr if_rdata", bus.if_rdata, 32'hDEADBEEF);

      // Misaligned fetch and out-of-range debug read
      next_cycle(); bus.if_req = 1; bus.if_addr = 32'h2;
      #3 chk("err if_gnt", 32'(bus.if_gnt), 1);
      chk("err mem_ena f", 32'(bus.mem_ena), 0);
      next_cycle(); bus.if_req = 0; bus.dbg_req = 1; bus.dbg_addr = 32'h0000_2000;
      #3 chk("err dbg_gnt", 32'(bus.dbg_gnt), 1);
      chk("err mem_ena d", 32'(bus.mem_ena), 0);
      chk("err if_err", 32'(bus.if_err), 1);
      chk("err if_rdata", bus.if_rdata, 0);
      next_cycle(); bus.dbg_req = 0;
      #3 chk("err dbg_err", 32'(bus.dbg_err), 1);
      chk("err dbg_rdata", bus.dbg_rdata, 0);

      // Reset pulsed the cycle after a grant discards the response
      next_cycle(); bus.if_req = 1; bus.if_addr = 32'h8;
      #3 chk("rp if_gnt", 32'(bus.if_gnt), 1);
      next_cycle(); rst = 1; bus.if_req = 0;
      #1 chk("rp if_rvalid", 32'(bus.if_rvalid), 0);
      chk("rp stall", 32'(bus.stall_cnt), 0);
      next_cycle(); rst = 0;
      #3 chk("rp after if_rvalid", 32'(bus.if_rvalid), 0);

      // Random traffic; requesters hold until granted, occasionally drop
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         g_f = bus.if_gnt;
         g_d = bus.dbg_gnt;
         next_cycle();
         if (!bus.if_req || g_f || $urandom_range(0, 15) == 0) begin
            bus.if_req  = $urandom_range(0, 3) != 0;
            bus.if_addr = rand_addr();
         end
         if (!bus.dbg_req || g_d || $urandom_range(0, 15) == 0) begin
            bus.dbg_req   = $urandom_range(0, 2) != 0;
            bus.dbg_we    = $urandom_range(0, 2) == 0;
            bus.dbg_addr  = rand_addr();
            bus.dbg_wdata = $urandom();
         end
         bus.dbg_halt = $urandom_range(0, 9) == 0;
      end

      // Long halt with fetch pending: counter must saturate
      next_cycle();
      bus.dbg_req = 0; bus.dbg_halt = 1; bus.if_req = 1; bus.if_addr = 32'h0;
      repeat (70000) @(posedge clk);
      #3 chk("halt stall_cnt", 32'(bus.stall_cnt), 32'hFFFF);
      chk("halt if_gnt", 32'(bus.if_gnt), 0);
      next_cycle(); bus.if_req = 0; bus.dbg_halt = 0;
      next_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/im_port_arbiter.md
IM_PORT_ARBITER -- requirements
Module: im_port_arbiter

Interface
REQ-001 Parameter AW, default 11: word-address width driven to the instruction memory, covering byte addresses [AW+1:2].
REQ-002 clk  input  1  single clock for all logic and for the instruction memory port.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  fetch read request.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid  output  1  fetch response valid.
REQ-008 if_rdata  output  32  fetch read data.
REQ-009 if_err  output  1  fetch response is an address error.
REQ-010 dbg_req  input  1  debug/loader request.
REQ-011 dbg_we  input  1  debug request is a write.
REQ-012 dbg_addr  input  32  debug byte address.
REQ-013 dbg_wdata  input  32  debug write data.
REQ-014 dbg_halt  input  1  while high, fetch requests are never granted.
REQ-015 dbg_gnt, dbg_rvalid, dbg_err  output  1 each  debug accept, response valid, error flag.
REQ-016 dbg_rdata  output  32  debug read data.
REQ-017 mem_ena, mem_wea  output  1 each  memory enable and write enable.
REQ-018 mem_addr  output  AW  memory word address.
REQ-019 mem_dina  output  32  memory write data.
REQ-020 mem_douta  input  32  memory read data, valid one cycle after mem_ena.
REQ-021 stall_cnt  output  16  fetch-starvation counter.

Function
REQ-022 Each cycle, at most one requester SHALL be granted; grant outputs are combinational from req, dbg_halt and the last-grant register.
REQ-023 Fetch eligibility SHALL be if_req & ~dbg_halt, and debug eligibility SHALL be dbg_req.
REQ-024 When only one requester is eligible, that requester SHALL be granted.
REQ-025 When both are eligible, the requester not granted most recently SHALL be granted (round-robin), and last_gnt SHALL update on every grant.
REQ-026 A request SHALL be legal when addr[1:0]==0 and addr[31:AW+2]==0.
REQ-027 A legal grant SHALL drive mem_ena=1, mem_addr=addr[AW+1:2], mem_wea=dbg_we for debug grants and 0 for fetch grants, and mem_dina=dbg_wdata.
REQ-028 An illegal grant SHALL drive mem_ena=0 and mem_wea=0.
REQ-029 With no grant, mem_ena and mem_wea SHALL be 0, and mem_addr and mem_dina are don't-care.
REQ-030 A one-entry response register (owner, is_write, err, valid) SHALL capture each grant.
REQ-031 Exactly one cycle after a grant, the owner's rvalid SHALL pulse high for one cycle; latency is fixed at 1.
REQ-032 The read response rdata SHALL equal mem_douta.
REQ-033 Write responses and error responses SHALL return rdata=0, and an error response SHALL drive the owner's err=1.
REQ-034 The non-owner's rvalid, err and rdata SHALL be 0.
REQ-035 Back-to-back grants SHALL be supported every cycle, with no bubble.
REQ-036 Requesters SHALL hold req and its payload until gnt; dropping req before gnt SHALL leave no trace.
REQ-037 stall_cnt SHALL increment each cycle that if_req=1 and if_gnt=0 (including during halt), saturate at 16'hFFFF, and never wrap.
REQ-038 Asserting dbg_halt SHALL NOT cancel a fetch response already in flight.

Reset
REQ-039 While rst=1, asynchronously: all gnt, rvalid and err outputs SHALL be 0, mem_ena=mem_wea=0, rdata=0, stall_cnt=0, the response register SHALL be invalid, and last_gnt=debug (fetch wins the first tie).
REQ-040 A response in flight when rst asserts SHALL be discarded, with no rvalid after rst deasserts.
REQ-041 The first grant SHALL be possible on the first clock edge after rst deasserts.

Verification
REQ-042 Reset release; if_req=1 and if_addr=0x10 only -> if_gnt same cycle, mem_addr=4, mem_wea=0; next cycle if_rvalid=1 and if_rdata equals memory word 4.
REQ-043 Both requesters request continuously with legal reads -> grants alternate fetch, debug, fetch, debug; each rvalid goes to the correct owner one cycle later.
REQ-044 dbg_we=1, dbg_addr=0x20, dbg_wdata=0xDEADBEEF, then a fetch of 0x20 -> mem_wea=1 at address 8; the fetch returns 0xDEADBEEF; the write response has dbg_rdata=0.
REQ-045 Fetch of 0x2 and debug read of 0x0000_2000 (AW=11) -> both granted in turn with mem_ena=0; responses have err=1 and rdata=0.
REQ-046 dbg_halt=1 with if_req=1 held for 70000 cycles -> if_gnt never asserts and stall_cnt saturates at 0xFFFF.
REQ-047 rst pulsed the cycle after a grant -> no rvalid, and all outputs equal the REQ-039 values.
